l15_mem_responder: RTL and testbench

//  L1.5-side responder for the OpenPiton L15 request/return interface driven by the core wrapper.

---
 rtl/l15_resp_pkg.sv | 66 ++++++
 rtl/l15_resp_mem.sv | 30 +++
 rtl/l15_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_l15_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l15_resp_pkg.sv
// Shared types, request/return codes and helpers for the L1.5 memory responder.
// Request/return encodings match the core wrapper's cache package.
package l15_resp_pkg;

  localparam int unsigned L15TidWidth = 2;

  localparam logic [4:0] L15LoadRq   = 5'b00000;
  localparam logic [4:0] L15ImissRq  = 5'b10000;
  localparam logic [4:0] L15StoreRq  = 5'b00001;

  localparam logic [3:0] L15LoadRet  = 4'b0000;
  localparam logic [3:0] L15IfillRet = 4'b0001;
  localparam logic [3:0] L15StAck    = 4'b0100;

  localparam logic [1:0] ErrNone  = 2'b00;
  localparam logic [1:0] ErrUnsup = 2'b10;
  localparam logic [1:0] ErrRange = 2'b11;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  typedef struct packed {
    logic                   l15_val;
    logic                   l15_req_ack;
    logic [4:0]             l15_rqtype;
    logic                   l15_nc;
    logic [2:0]             l15_size;
    logic [L15TidWidth-1:0] l15_threadid;
    logic [39:0]            l15_address;
    logic [63:0]            l15_data;
  } l15_req_t;

  typedef struct packed {
    logic                   l15_ack;
    logic                   l15_header_ack;
    logic                   l15_val;
    logic [3:0]             l15_returntype;
    logic [1:0]             l15_error;
    logic                   l15_noncacheable;
    logic [L15TidWidth-1:0] l15_threadid;
    logic [63:0]            l15_data_0;
    logic [63:0]            l15_data_1;
    logic [63:0]            l15_data_2;
    logic [63:0]            l15_data_3;
  } l15_rtrn_t;

  // Returns 0 for unsupported sizes or misaligned offsets.
  function automatic logic [7:0] size_to_be(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] be;
    be = 8'h00;
    case (size)
      3'd0: be = 8'h01 << off;
      3'd1: if (off[0] == 1'b0) be = 8'h03 << off;
      3'd2: if (off[1:0] == 2'b00) be = 8'h0F << off;
      3'd3: if (off == 3'b000) be = 8'hFF;
      default: be = 8'h00;
    endcase
    return be;
  endfunction

  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

endpackage

// File: rtl/l15_resp_mem.sv
// Word memory for the L1.5 responder: one byte-enabled write port and
// four combinational reads covering an aligned 4-word line.
module l15_resp_mem #(
  parameter int unsigned Words = 4096,
  localparam int unsigned IdxW = $clog2(Words)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IdxW-1:0]  widx_i,
  input  logic [7:0]       wbe_i,
  input  logic [63:0]      wdata_i,
  input  logic [IdxW-3:0]  rline_i,
  output logic [3:0][63:0] rdata_o
);

  logic [63:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (wbe_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) rdata_o[k] = mem_q[{rline_i, 2'(k)}];
  end

endmodule

// File: rtl/l15_mem_responder.sv
// L1.5 stand-in: accepts one l15 request at a time, services it from local memory
// and returns the rtrn packet a fixed number of cycles after the ack.
module l15_mem_responder
  import l15_resp_pkg::*;
#(
  parameter logic [63:0] MEM_BASE    = 64'h8000_0000,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned LATENCY     = 4,
  parameter bit          SWAP_ENDIAN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  l15_req_t    l15_req_i,
  output l15_rtrn_t   l15_rtrn_o,
  output logic        busy_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [3:0]        ret_q;
  logic [1:0]        err_q;
  logic              nc_q;
  logic [1:0]        tid_q;
  logic [IdxW-1:0]   idx_q;

  logic [63:0]       addr64, off;
  logic              in_win, accept, we;
  logic [7:0]        be, mem_be;
  logic [63:0]       mem_wdata;
  logic [IdxW-1:0]   req_idx;
  logic [3:0]        req_ret;
  logic [1:0]        req_err;
  logic [3:0][63:0]  rd;

  function automatic logic [63:0] to_core(input logic [63:0] w);
    return SWAP_ENDIAN ? bswap64(w) : w;
  endfunction

  always_comb begin
    addr64  = {24'd0, l15_req_i.l15_address};
    off     = addr64 - MEM_BASE;
    in_win  = (addr64 >= MEM_BASE) && (off < 64'(MEM_WORDS) * 64'd8);
    req_idx = off[IdxW+2:3];
    be      = size_to_be(l15_req_i.l15_size, l15_req_i.l15_address[2:0]);
    req_ret = L15StAck;
    req_err = ErrUnsup;
    case (l15_req_i.l15_rqtype)
      L15LoadRq: begin
        req_ret = L15LoadRet;
        req_err = in_win ? ErrNone : ErrRange;
      end
      L15ImissRq: begin
        req_ret = L15IfillRet;
        req_err = in_win ? ErrNone : ErrRange;
      end
      L15StoreRq: begin
        req_ret = L15StAck;
        req_err = !in_win ? ErrRange : ((be == 8'h00) ? ErrUnsup : ErrNone);
      end
      default: ;
    endcase
  end

  assign accept = (state_q == StIdle) && l15_req_i.l15_val;
  assign we     = accept && (l15_req_i.l15_rqtype == L15StoreRq) && (req_err == ErrNone);

  // Byte lane k lands on memory byte 7-k when the lanes are swapped.
  always_comb begin
    mem_be    = be;
    mem_wdata = l15_req_i.l15_data;
    if (SWAP_ENDIAN) begin
      for (int k = 0; k < 8; k++) mem_be[k] = be[7-k];
      mem_wdata = bswap64(l15_req_i.l15_data);
    end
  end

  l15_resp_mem #(
    .Words(MEM_WORDS)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (we),
    .widx_i  (req_idx),
    .wbe_i   (mem_be),
    .wdata_i (mem_wdata),
    .rline_i (idx_q[IdxW-1:2]),
    .rdata_o (rd)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (l15_req_i.l15_val) begin
          cnt_d   = 16'(LATENCY - 1);
          state_d = (LATENCY <= 1) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) state_d = StResp;
      end
      StResp: begin
        if (l15_req_i.l15_req_ack) begin
          state_d = StIdle;
          if (err_q != ErrNone && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      ret_q     <= '0;
      err_q     <= '0;
      nc_q      <= 1'b0;
      tid_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      if (accept) begin
        ret_q <= req_ret;
        err_q <= req_err;
        nc_q  <= l15_req_i.l15_nc;
        tid_q <= l15_req_i.l15_threadid;
        idx_q <= req_idx;
      end
    end
  end

  // Memory is only written in IDLE, so reads from the captured index stay stable in RESP.
  always_comb begin
    l15_rtrn_o                = '0;
    l15_rtrn_o.l15_ack        = accept;
    l15_rtrn_o.l15_header_ack = accept;
    if (state_q == StResp) begin
      l15_rtrn_o.l15_val          = 1'b1;
      l15_rtrn_o.l15_returntype   = ret_q;
      l15_rtrn_o.l15_error        = err_q;
      l15_rtrn_o.l15_threadid     = tid_q;
      l15_rtrn_o.l15_noncacheable = (ret_q == L15LoadRet) && nc_q;
      if (err_q == ErrNone) begin
        case (ret_q)
          L15LoadRet: begin
            if (nc_q) begin
              l15_rtrn_o.l15_data_0 = to_core(rd[idx_q[1:0]]);
              l15_rtrn_o.l15_data_1 = to_core(rd[idx_q[1:0]]);
            end else begin
              l15_rtrn_o.l15_data_0 = to_core(rd[{idx_q[1], 1'b0}]);
              l15_rtrn_o.l15_data_1 = to_core(rd[{idx_q[1], 1'b1}]);
            end
          end
          L15IfillRet: begin
            l15_rtrn_o.l15_data_0 = to_core(rd[0]);
            l15_rtrn_o.l15_data_1 = to_core(rd[1]);
            l15_rtrn_o.l15_data_2 = to_core(rd[2]);
            l15_rtrn_o.l15_data_3 = to_core(rd[3]);
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_l15_mem_responder.sv
// Self-checking bench for l15_mem_responder: directed table, multi-cycle corner
// sequences and random traffic against a byte-addressed core-view memory model.
module tb_l15_mem_responder;
  import l15_resp_pkg::*;

  localparam longint unsigned BASE = 64'h8000_0000;
  localparam int unsigned     MW   = 256;
  localparam int unsigned     LAT  = 4;
  localparam logic [4:0]      AMO  = 5'b00110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  l15_req_t    req;
  l15_rtrn_t   rtrn;
  logic        busy;
  logic [15:0] err_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mdl [MW];
  logic [15:0] err_m = 16'd0;

  always #5 clk = ~clk;

  l15_mem_responder #(
    .MEM_BASE    (64'h8000_0000),
    .MEM_WORDS   (MW),
    .LATENCY     (LAT),
    .SWAP_ENDIAN (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .l15_req_i  (req),
    .l15_rtrn_o (rtrn),
    .busy_o     (busy),
    .err_cnt_o  (err_cnt)
  );

  typedef struct {
    logic [4:0]  rq;
    logic        nc;
    logic [2:0]  sz;
    logic [1:0]  tid;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  rtype;
    logic [1:0]  err;
    logic [63:0] d0;
    logic [63:0] d1;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [63:0] pre(input int i);
    return 64'h0123_4567_0000_0000 + 64'(i);
  endfunction

  function automatic l15_req_t mk(input logic [4:0] rq, input logic nc, input logic [2:0] sz,
                                  input logic [1:0] tid, input logic [63:0] addr,
                                  input logic [63:0] data);
    l15_req_t r;
    r = '0;
    r.l15_rqtype   = rq;
    r.l15_nc       = nc;
    r.l15_size     = sz;
    r.l15_threadid = tid;
    r.l15_address  = addr[39:0];
    r.l15_data     = data;
    return r;
  endfunction

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core-view model: byte b of the window sits in lane b%8 of word b/8.
  task automatic model(input l15_req_t r, output l15_rtrn_t e);
    longint unsigned a, bo;
    bit inwin;
    int w, nb, lane;
    e = '0;
    e.l15_val      = 1'b1;
    e.l15_threadid = r.l15_threadid;
    a     = 64'(r.l15_address);
    inwin = (a >= BASE) && (a < BASE + MW * 8);
    case (r.l15_rqtype)
      L15LoadRq: begin
        e.l15_returntype   = L15LoadRet;
        e.l15_noncacheable = r.l15_nc;
        if (!inwin) e.l15_error = 2'b11;
        else if (r.l15_nc) begin
          w = int'((a - BASE) / 8);
          e.l15_data_0 = mdl[w];
          e.l15_data_1 = mdl[w];
        end else begin
          w = int'((a - BASE) / 16) * 2;
          e.l15_data_0 = mdl[w];
          e.l15_data_1 = mdl[w+1];
        end
      end
      L15ImissRq: begin
        e.l15_returntype = L15IfillRet;
        if (!inwin) e.l15_error = 2'b11;
        else begin
          w = int'((a - BASE) / 32) * 4;
          e.l15_data_0 = mdl[w];
          e.l15_data_1 = mdl[w+1];
          e.l15_data_2 = mdl[w+2];
          e.l15_data_3 = mdl[w+3];
        end
      end
      L15StoreRq: begin
        e.l15_returntype = L15StAck;
        if (!inwin) e.l15_error = 2'b11;
        else if (r.l15_size > 3'd3) e.l15_error = 2'b10;
        else begin
          nb = 1 << r.l15_size;
          if (a % nb != 0) e.l15_error = 2'b10;
          else begin
            for (int j = 0; j < nb; j++) begin
              bo   = a - BASE + j;
              lane = int'(bo % 8);
              mdl[int'(bo / 8)][8*lane +: 8] = r.l15_data[8*lane +: 8];
            end
          end
        end
      end
      default: begin
        e.l15_returntype = L15StAck;
        e.l15_error      = 2'b10;
      end
    endcase
  endtask

  // Presents r for its ack cycle, then leaves nxt on the bus.
  task automatic send(input l15_req_t r, input l15_req_t nxt, output l15_rtrn_t e);
    @(posedge clk); #1;
    req = r;
    req.l15_val = 1'b1;
    req.l15_req_ack = 1'b0;
    @(negedge clk);
    check("ack", {rtrn.l15_ack, rtrn.l15_header_ack, busy}, 3'b110);
    model(r, e);
    @(posedge clk); #1;
    req = nxt;
    req.l15_req_ack = 1'b0;
  endtask

  task automatic collect(input l15_rtrn_t e, input int hold, input bit pend,
                         output l15_rtrn_t got);
    int n;
    n = 1;
    @(negedge clk);
    while (!rtrn.l15_val && n < 40) begin
      check("ack_in_wait", {rtrn.l15_ack, rtrn.l15_header_ack}, 2'b00);
      @(negedge clk);
      n++;
    end
    got = rtrn;
    check("latency", n, LAT);
    if (!rtrn.l15_val) return;
    check("rtrn", got, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold", rtrn, got);
    end
    @(posedge clk); #1;
    req.l15_req_ack = 1'b1;
    @(negedge clk);
    check("accept", rtrn, got);
    if (e.l15_error != 2'b00 && err_m != 16'hFFFF) err_m++;
    @(posedge clk); #1;
    req.l15_req_ack = 1'b0;
    @(negedge clk);
    check("idle", {rtrn.l15_val, busy, rtrn.l15_ack, err_cnt}, {1'b0, 1'b0, pend, err_m});
  endtask

  function automatic l15_req_t rnd_req();
    l15_req_t r;
    int unsigned k, nb;
    r = '0;
    k = $urandom_range(0, 99);
    r.l15_rqtype   = (k < 35) ? L15LoadRq : (k < 55) ? L15ImissRq : (k < 90) ? L15StoreRq :
                     ($urandom_range(0, 1) != 0) ? AMO : 5'b00101;
    r.l15_nc       = 1'($urandom_range(0, 1));
    r.l15_size     = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7))
                                                  : 3'($urandom_range(0, 3));
    r.l15_threadid = 2'($urandom);
    r.l15_address  = 40'(BASE + 64'($urandom_range(0, 511)));
    if (r.l15_size <= 3'd3 && $urandom_range(0, 3) != 0) begin
      nb = 1 << r.l15_size;
      r.l15_address = r.l15_address & ~40'(nb - 1);
    end
    if ($urandom_range(0, 9) == 0)
      r.l15_address = ($urandom_range(0, 1) != 0) ? 40'(BASE - 64'($urandom_range(1, 64)))
                                                  : 40'(BASE + MW * 8 + $urandom_range(0, 64));
    r.l15_data = {$urandom, $urandom};
    return r;
  endfunction

  initial begin
    l15_req_t  idle, ra, rb;
    l15_rtrn_t e, eb, got;
    logic [63:0] w2, sw;

    idle = '0;
    req  = '0;
    for (int i = 0; i < int'(MW); i++) mdl[i] = '0;

    tbl[0]  = '{L15LoadRq,  1'b0, 3'd3, 2'd1, BASE + 64'h10, 64'd0, L15LoadRet, 2'b00, pre(2), pre(3)};
    tbl[1]  = '{L15ImissRq, 1'b0, 3'd0, 2'd2, BASE + 64'h24, 64'd0, L15IfillRet, 2'b00, pre(4), pre(5)};
    tbl[2]  = '{L15StoreRq, 1'b0, 3'd0, 2'd0, BASE + 64'h03, 64'hEFEF_EFEF_EFEF_EFEF,
                L15StAck, 2'b00, 64'd0, 64'd0};
    tbl[3]  = '{L15LoadRq,  1'b1, 3'd3, 2'd3, BASE, 64'd0, L15LoadRet, 2'b00,
                64'h0123_4567_EF00_0000, 64'h0123_4567_EF00_0000};
    tbl[4]  = '{L15LoadRq,  1'b0, 3'd3, 2'd0, 64'h7FFF_FFF8, 64'd0, L15LoadRet, 2'b11, 64'd0, 64'd0};
    tbl[5]  = '{L15StoreRq, 1'b0, 3'd3, 2'd1, BASE + 64'h04, 64'd1, L15StAck, 2'b10, 64'd0, 64'd0};
    tbl[6]  = '{AMO,        1'b0, 3'd3, 2'd2, BASE + 64'h08, 64'd1, L15StAck, 2'b10, 64'd0, 64'd0};
    tbl[7]  = '{L15LoadRq,  1'b1, 3'd3, 2'd0, BASE + 64'h800, 64'd0, L15LoadRet, 2'b11, 64'd0, 64'd0};
    tbl[8]  = '{L15LoadRq,  1'b1, 3'd3, 2'd1, BASE + 64'h7F8, 64'd0, L15LoadRet, 2'b00,
                64'hFEED_FACE_CAFE_BEEF, 64'hFEED_FACE_CAFE_BEEF};
    tbl[9]  = '{L15StoreRq, 1'b0, 3'd1, 2'd2, BASE + 64'h01, 64'd0, L15StAck, 2'b10, 64'd0, 64'd0};
    tbl[10] = '{L15StoreRq, 1'b0, 3'd2, 2'd3, BASE + 64'h14, 64'h1234_5678_9ABC_DEF0,
                L15StAck, 2'b00, 64'd0, 64'd0};
    tbl[11] = '{L15LoadRq,  1'b0, 3'd3, 2'd0, BASE + 64'h18, 64'd0, L15LoadRet, 2'b00,
                64'h1234_5678_0000_0002, pre(3)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", {rtrn, busy, err_cnt}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      send(mk(L15StoreRq, 1'b0, 3'd3, 2'd0, BASE + 64'(8 * i), pre(i)), idle, e);
      collect(e, 0, 1'b0, got);
    end
    send(mk(L15StoreRq, 1'b0, 3'd3, 2'd1, BASE + 64'h7F8, 64'hFEED_FACE_CAFE_BEEF), idle, e);
    collect(e, 0, 1'b0, got);

    // Memory holds each word byte-reversed relative to the core's view.
    w2 = pre(2);
    sw = {<<8{w2}};
    check("mem_swap", dut.u_mem.mem_q[2], sw);

    for (int i = 0; i < 12; i++) begin
      send(mk(tbl[i].rq, tbl[i].nc, tbl[i].sz, tbl[i].tid, tbl[i].addr, tbl[i].data), idle, e);
      collect(e, i % 3, 1'b0, got);
      check($sformatf("tbl%0d", i),
            {got.l15_returntype, got.l15_error, got.l15_data_0, got.l15_data_1},
            {tbl[i].rtype, tbl[i].err, tbl[i].d0, tbl[i].d1});
    end
    check("err_cnt_tbl", err_cnt, 16'd5);

    // Response withheld 10 cycles while a second request waits on the bus.
    ra = mk(L15LoadRq, 1'b0, 3'd3, 2'd1, BASE + 64'h30, 64'd0);
    rb = mk(L15ImissRq, 1'b0, 3'd0, 2'd2, BASE + 64'h40, 64'd0);
    rb.l15_val = 1'b1;
    send(ra, rb, e);
    collect(e, 10, 1'b1, got);
    model(rb, eb);
    @(posedge clk); #1;
    req = idle;
    collect(eb, 0, 1'b0, got);

    // Reset while waiting drops the request.
    send(mk(L15LoadRq, 1'b1, 3'd3, 2'd0, BASE + 64'h08, 64'd0), idle, e);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_wait", {rtrn.l15_val, busy, err_cnt}, 18'd0);
    err_m = 16'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("dropped", {rtrn.l15_val, busy}, 2'b00);
    end
    send(mk(L15ImissRq, 1'b0, 3'd0, 2'd3, BASE + 64'h1C, 64'd0), idle, e);
    collect(e, 1, 1'b0, got);

    for (int t = 0; t < 150; t++) begin
      send(rnd_req(), idle, e);
      collect(e, int'($urandom_range(0, 3)), 1'b0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
